// File: rtl/snake_pkg.sv
// snake_pkg: types and constants shared by the snake game, the food logic and
// the seed generator.
//   seed_state_t  : seed generator FSM states
//   SEED_W        : width of one board coordinate (cells 0..31)
//   LFSR_MASK     : Galois feedback mask for x^16+x^14+x^13+x^11
//   BOARD_*_CELLS : default playfield size in cells
package snake_pkg;

  localparam int          SEED_W        = 5;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam int          BOARD_W_CELLS = 24;
  localparam int          BOARD_H_CELLS = 18;

  typedef enum logic [2:0] {
    IDLE,
    GEN_X,
    GEN_Y,
    ISSUE,
    COOL
  } seed_state_t;

endpackage

// File: rtl/seed_gen_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (right-shifting, feedback mask
// LFSR_MASK). It advances on every clock out of reset and never reaches zero
// when INIT is nonzero.
//   clk : system clock
//   rst : synchronous active-high reset, loads INIT
//   q   : current LFSR state
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] INIT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic [15:0] q_next;

  // Each bit takes its upper neighbour, XORed with the bit shifted out of the
  // bottom wherever the mask has a tap. The top bit has no upper neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      if (gi == 15) begin : g_top
        assign q_next[gi] = LFSR_MASK[gi] & q_reg[0];
      end else begin : g_mid
        assign q_next[gi] = q_reg[gi+1] ^ (LFSR_MASK[gi] & q_reg[0]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= INIT;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/seed_gen.sv
// seed_gen: produces an in-bounds random (x, y) seed for food/spawn placement
// on a local start request and arbitrates the master/slave role against a
// start arriving from the remote board.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   start_req    : debounced local start level, acted on at its rising edge
//   remote_start : remote seed received flag, acted on at its rising edge
//   seed_rdy     : one-cycle pulse, seed valid for transmission
//   seed_x/y     : seed coordinates, held until the next issue
//   local_start  : one-cycle pulse coincident with seed_rdy
//   is_master    : 1 when this board generated the last seed
//   busy         : high while generating, issuing or cooling down
module seed_gen
  import snake_pkg::*;
#(
  parameter int          BOARD_W   = BOARD_W_CELLS,
  parameter int          BOARD_H   = BOARD_H_CELLS,
  parameter logic [15:0] LFSR_INIT = 16'hACE1,
  parameter int          MAX_RETRY = 4,
  parameter int          COOLDOWN  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_req,
  input  logic              remote_start,
  output logic              seed_rdy,
  output logic [SEED_W-1:0] seed_x,
  output logic [SEED_W-1:0] seed_y,
  output logic              local_start,
  output logic              is_master,
  output logic              busy
);

  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [SEED_W:0]   W_EXT = (SEED_W + 1)'(BOARD_W);
  localparam logic [SEED_W:0]   H_EXT = (SEED_W + 1)'(BOARD_H);
  localparam logic [SEED_W-1:0] W_LO  = SEED_W'(BOARD_W);
  localparam logic [SEED_W-1:0] H_LO  = SEED_W'(BOARD_H);

  seed_state_t       state_reg, state_next;
  logic [RW-1:0]     retry_reg, retry_next;
  logic [CW-1:0]     cool_reg, cool_next;
  logic [SEED_W-1:0] seed_x_reg, seed_x_next;
  logic [SEED_W-1:0] seed_y_reg, seed_y_next;
  logic              is_master_reg, is_master_next;
  logic              seed_rdy_reg;
  logic              local_start_reg;
  logic              busy_reg;

  // Edge detectors hold "input was low last cycle". Clearing them on reset
  // means a level held high through reset is not mistaken for a new press.
  logic start_low_reg;
  logic remote_low_reg;
  logic start_rise;
  logic remote_rise;

  logic [15:0]       lfsr;
  logic              lfsr_unused;
  logic [SEED_W-1:0] cand;
  logic              cand_in_w;
  logic              cand_in_h;
  logic              retry_last;

  lfsr16 #(
    .INIT (LFSR_INIT)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign cand        = lfsr[SEED_W-1:0];
  assign lfsr_unused = ^lfsr[15:SEED_W];
  assign cand_in_w   = ({1'b0, cand} < W_EXT);
  assign cand_in_h   = ({1'b0, cand} < H_EXT);
  assign retry_last  = (retry_reg == RW'(MAX_RETRY - 1));

  assign start_rise  = start_req & start_low_reg;
  assign remote_rise = remote_start & remote_low_reg;

  always_comb begin
    state_next     = state_reg;
    retry_next     = retry_reg;
    cool_next      = cool_reg;
    seed_x_next    = seed_x_reg;
    seed_y_next    = seed_y_reg;
    is_master_next = is_master_reg;
    case (state_reg)
      IDLE: begin
        // Remote start takes priority: the other board is already master.
        if (remote_rise) begin
          is_master_next = 1'b0;
        end else if (start_rise) begin
          retry_next = '0;
          state_next = GEN_X;
        end
      end
      GEN_X: begin
        if (remote_rise) begin
          is_master_next = 1'b0;
          state_next     = IDLE;
        end else if (cand_in_w) begin
          seed_x_next = cand;
          retry_next  = '0;
          state_next  = GEN_Y;
        end else if (retry_last) begin
          // Out of retries: fold the candidate back into range. Since the
          // board is at least 16 wide, cand - BOARD_W always lands inside it.
          seed_x_next = cand - W_LO;
          retry_next  = '0;
          state_next  = GEN_Y;
        end else begin
          retry_next = retry_reg + RW'(1);
        end
      end
      GEN_Y: begin
        if (remote_rise) begin
          is_master_next = 1'b0;
          state_next     = IDLE;
        end else if (cand_in_h) begin
          seed_y_next = cand;
          retry_next  = '0;
          state_next  = ISSUE;
        end else if (retry_last) begin
          seed_y_next = cand - H_LO;
          retry_next  = '0;
          state_next  = ISSUE;
        end else begin
          retry_next = retry_reg + RW'(1);
        end
      end
      ISSUE: begin
        // A remote start arriving now is ignored so the issue completes.
        is_master_next = 1'b1;
        cool_next      = CW'(COOLDOWN - 1);
        state_next     = COOL;
      end
      COOL: begin
        if (remote_rise) begin
          is_master_next = 1'b0;
          state_next     = IDLE;
        end else if (cool_reg == '0) begin
          state_next = IDLE;
        end else begin
          cool_next = cool_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      retry_reg       <= '0;
      cool_reg        <= '0;
      seed_x_reg      <= '0;
      seed_y_reg      <= '0;
      is_master_reg   <= 1'b0;
      seed_rdy_reg    <= 1'b0;
      local_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      start_low_reg   <= 1'b0;
      remote_low_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      retry_reg       <= retry_next;
      cool_reg        <= cool_next;
      seed_x_reg      <= seed_x_next;
      seed_y_reg      <= seed_y_next;
      is_master_reg   <= is_master_next;
      // ISSUE lasts exactly one cycle, so these are single-cycle pulses
      // that line up with is_master rising.
      seed_rdy_reg    <= (state_reg == ISSUE);
      local_start_reg <= (state_reg == ISSUE);
      busy_reg        <= (state_next != IDLE);
      start_low_reg   <= ~start_req;
      remote_low_reg  <= ~remote_start;
    end
  end

  assign seed_rdy    = seed_rdy_reg;
  assign local_start = local_start_reg;
  assign seed_x      = seed_x_reg;
  assign seed_y      = seed_y_reg;
  assign is_master   = is_master_reg;
  assign busy        = busy_reg;

endmodule
